// File: rtl/serv_rf_dbg_arb_if.sv
// Bundle of the core RF port, the 32-bit debug port and the RF RAM port
// around serv_rf_dbg_arb. slave = arbiter view, master = surrounding system.
interface serv_rf_dbg_arb_if #(
    parameter int WITH_CSR = 1,
    parameter int DW       = 2
);
    localparam int N  = 32 / DW;
    localparam int RW = 5 + WITH_CSR;
    localparam int AW = RW + $clog2(N);

    logic          core_req;
    logic          core_gnt;
    logic [AW-1:0] core_waddr;
    logic [DW-1:0] core_wdata;
    logic          core_wen;
    logic [AW-1:0] core_raddr;
    logic          core_ren;
    logic [DW-1:0] core_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [RW-1:0] dbg_reg;
    logic [31:0]   dbg_wdata;
    logic          dbg_busy;
    logic          dbg_ack;
    logic [31:0]   dbg_rdata;

    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wen;
    logic [AW-1:0] ram_raddr;
    logic          ram_ren;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  core_req, core_waddr, core_wdata, core_wen, core_raddr, core_ren,
        output core_gnt, core_rdata,
        input  dbg_req, dbg_we, dbg_reg, dbg_wdata,
        output dbg_busy, dbg_ack, dbg_rdata,
        output ram_waddr, ram_wdata, ram_wen, ram_raddr, ram_ren,
        input  ram_rdata
    );

    modport master (
        output core_req, core_waddr, core_wdata, core_wen, core_raddr, core_ren,
        input  core_gnt, core_rdata,
        output dbg_req, dbg_we, dbg_reg, dbg_wdata,
        input  dbg_busy, dbg_ack, dbg_rdata,
        input  ram_waddr, ram_wdata, ram_wen, ram_raddr, ram_ren,
        output ram_rdata
    );
endinterface

// File: rtl/serv_rf_dbg_arb.sv
// Shares the SERV RF RAM between the core and a debug port; a buffered debug
// access is split into 32/DW word accesses whenever the core does not hold the RAM.
module serv_rf_dbg_arb #(
    parameter int WITH_CSR = 1,
    parameter int DW       = 2
) (
    input logic              clk,
    input logic              rst,
    serv_rf_dbg_arb_if.slave bus
);
    localparam int N  = 32 / DW;
    localparam int LN = $clog2(N);
    localparam int CW = (LN > 0) ? LN : 1;
    localparam int RW = 5 + WITH_CSR;
    localparam int AW = RW + LN;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CORE = 3'd1;
    localparam logic [2:0] DWR  = 3'd2;
    localparam logic [2:0] DRD  = 3'd3;
    localparam logic [2:0] DACK = 3'd4;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [2:0]    state, nxt;
    logic          busy, pend_we, drain, cap;
    logic [RW-1:0] pend_reg;
    logic [31:0]   pend_wdata, rdata;
    logic [CW-1:0] cnt;

    logic          accept, go, go_we, cnt_end, tgt_ok, rd_issue;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] rd_word;
    logic [31:0]   rd_shift;

    assign accept   = bus.dbg_req && !busy;
    assign go       = busy || accept;
    assign go_we    = busy ? pend_we : bus.dbg_we;
    assign cnt_end  = (cnt == CNT_LAST);
    // x0 and the unused CSR slots must never be touched from the debug side
    assign tgt_ok   = (pend_reg != '0) && ((WITH_CSR == 0) || (32'(pend_reg) < 32'd36));
    assign rd_issue = (state == DRD) && !drain;
    assign rd_word  = tgt_ok ? bus.ram_rdata : '0;

    generate
        if (LN == 0) begin : g_one_word
            assign dbg_addr = pend_reg;
            assign rd_shift = rd_word;
        end else begin : g_multi_word
            assign dbg_addr = {pend_reg, cnt};
            assign rd_shift = {rd_word, rdata[31:DW]};
        end
    endgenerate

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.core_req) nxt = CORE;
                     else if (go)      nxt = go_we ? DWR : DRD;
            CORE:    if (!bus.core_req) nxt = go ? (go_we ? DWR : DRD) : IDLE;
            DWR:     if (cnt_end) nxt = DACK;
            DRD:     if (drain)   nxt = DACK;
            DACK:    nxt = bus.core_req ? CORE : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ram_waddr = dbg_addr;
        bus.ram_raddr = dbg_addr;
        bus.ram_wdata = pend_wdata[int'(cnt) * DW +: DW];
        bus.ram_wen   = 1'b0;
        bus.ram_ren   = 1'b0;
        case (state)
            CORE: begin
                bus.ram_waddr = bus.core_waddr;
                bus.ram_raddr = bus.core_raddr;
                bus.ram_wdata = bus.core_wdata;
                bus.ram_wen   = bus.core_wen;
                bus.ram_ren   = bus.core_ren;
            end
            DWR:     bus.ram_wen = tgt_ok;
            DRD:     bus.ram_ren = rd_issue && tgt_ok;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            pend_we    <= 1'b0;
            pend_reg   <= '0;
            pend_wdata <= '0;
            cnt        <= '0;
            drain      <= 1'b0;
            cap        <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= nxt;
            cap   <= rd_issue;
            // one extra DRD cycle so the last word's read data can be captured
            drain <= rd_issue && cnt_end;
            if (accept) begin
                busy       <= 1'b1;
                pend_we    <= bus.dbg_we;
                pend_reg   <= bus.dbg_reg;
                pend_wdata <= bus.dbg_wdata;
            end else if (state == DACK) begin
                busy <= 1'b0;
            end
            if (state == DWR || rd_issue)
                cnt <= cnt_end ? '0 : cnt + 1'b1;
            if (cap)
                rdata <= rd_shift;
        end
    end

    assign bus.core_gnt   = (state == CORE);
    assign bus.core_rdata = bus.ram_rdata;
    assign bus.dbg_busy   = busy;
    assign bus.dbg_ack    = (state == DACK);
    assign bus.dbg_rdata  = rdata;
endmodule

// File: tb/tb_serv_rf_dbg_arb.sv
// Directed bench for serv_rf_dbg_arb (WITH_CSR=1, DW=2) with a tenure-level
// reference model compared every cycle, plus literal timing/data expectations.
module tb_serv_rf_dbg_arb;
    localparam int WITH_CSR = 1;
    localparam int DW       = 2;
    localparam int N        = 16;
    localparam int AW       = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serv_rf_dbg_arb_if #(.WITH_CSR(WITH_CSR), .DW(DW)) bus ();
    serv_rf_dbg_arb #(.WITH_CSR(WITH_CSR), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RF RAM macro: synchronous write, registered read
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
        if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_regs [0:63];
    logic        m_core = 1'b0, m_busy = 1'b0, m_we = 1'b0;
    logic [5:0]  m_reg = '0;
    logic [31:0] m_wd = '0, m_rdata = '0;
    int          m_t = -1;   // cycle index inside the current debug tenure, -1 if none

    function automatic logic valid_reg(input logic [5:0] r);
        return (r != 6'd0) && (r < 6'd36);
    endfunction
    function automatic int tenure_last(input logic we);
        return we ? N : N + 1;
    endfunction

    initial for (int i = 0; i < 64; i++) ref_regs[i] = 32'h0;

    always @(negedge clk) begin
        if (rst) begin
            m_core = 1'b0; m_busy = 1'b0; m_t = -1; m_rdata = 32'h0;
        end else begin
            logic in_dbg;
            in_dbg = (m_t >= 0) && (m_t < N);
            chk("gnt",  bus.core_gnt, m_core);
            chk("busy", bus.dbg_busy, m_busy);
            chk("ack",  bus.dbg_ack, (m_t >= 0) && (m_t == tenure_last(m_we)));
            chk("core_rdata", bus.core_rdata, bus.ram_rdata);
            if (in_dbg) begin
                chk("dbg_wen", bus.ram_wen, m_we && valid_reg(m_reg));
                chk("dbg_ren", bus.ram_ren, !m_we && valid_reg(m_reg));
                if (bus.ram_wen) begin
                    chk("dbg_waddr", bus.ram_waddr, 32'(m_reg) * N + m_t);
                    chk("dbg_wdata", bus.ram_wdata, (m_wd >> (m_t * DW)) & 32'h3);
                end
                if (bus.ram_ren) chk("dbg_raddr", bus.ram_raddr, 32'(m_reg) * N + m_t);
            end else if (m_core) begin
                chk("core_wen", bus.ram_wen, bus.core_wen);
                chk("core_ren", bus.ram_ren, bus.core_ren);
                if (bus.ram_wen) begin
                    chk("core_waddr", bus.ram_waddr, bus.core_waddr);
                    chk("core_wdata", bus.ram_wdata, bus.core_wdata);
                end
                if (bus.ram_ren) chk("core_raddr", bus.ram_raddr, bus.core_raddr);
            end else begin
                chk("idle_wen", bus.ram_wen, 1'b0);
                chk("idle_ren", bus.ram_ren, 1'b0);
            end
            if (!(m_t >= 0 && !m_we && m_t < tenure_last(m_we)))
                chk("dbg_rdata", bus.dbg_rdata, m_rdata);

            // advance to the next cycle using this cycle's inputs
            if (m_core && bus.core_wen)
                ref_regs[bus.core_waddr / N][(bus.core_waddr % N) * DW +: DW] = bus.core_wdata;
            if (bus.dbg_req && !m_busy) begin
                m_busy = 1'b1; m_we = bus.dbg_we; m_reg = bus.dbg_reg; m_wd = bus.dbg_wdata;
            end
            if (m_t >= 0) begin
                if (m_t == tenure_last(m_we)) begin
                    if (m_we && valid_reg(m_reg)) ref_regs[m_reg] = m_wd;
                    m_t = -1; m_busy = 1'b0; m_core = bus.core_req;
                end else begin
                    m_t++;
                    if (!m_we && m_t == tenure_last(m_we))
                        m_rdata = valid_reg(m_reg) ? ref_regs[m_reg] : 32'h0;
                end
            end else if (m_core) begin
                if (!bus.core_req) begin
                    m_core = 1'b0;
                    if (m_busy) m_t = 0;
                end
            end else if (bus.core_req) begin
                m_core = 1'b1;
            end else if (m_busy) begin
                m_t = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int t0, ack_rel, n_wen, first_wen, last_wen, n_ren, first_ren, last_ren;
    logic [AW-1:0] first_waddr, first_raddr;
    logic [DW-1:0] first_wdata;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic dbg_pulse(input logic we, input logic [5:0] r, input logic [31:0] d);
        bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_reg = r; bus.dbg_wdata = d;
        t0 = cyc;
        tick();
        bus.dbg_req = 1'b0;
    endtask

    task automatic wait_ack(input int max);
        n_wen = 0; n_ren = 0; first_wen = -1; first_ren = -1; last_wen = -1; last_ren = -1;
        ack_rel = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.ram_wen && !bus.core_gnt) begin
                if (first_wen < 0) begin
                    first_wen = cyc - t0; first_waddr = bus.ram_waddr; first_wdata = bus.ram_wdata;
                end
                last_wen = cyc - t0; n_wen++;
            end
            if (bus.ram_ren && !bus.core_gnt) begin
                if (first_ren < 0) begin first_ren = cyc - t0; first_raddr = bus.ram_raddr; end
                last_ren = cyc - t0; n_ren++;
            end
            if (bus.dbg_ack) begin ack_rel = cyc - t0; break; end
        end
        if (ack_rel < 0) chk("ack_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        int extra;
        bus.core_req = 0; bus.core_waddr = '0; bus.core_wdata = '0; bus.core_wen = 0;
        bus.core_raddr = '0; bus.core_ren = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_reg = '0; bus.dbg_wdata = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_gnt", bus.core_gnt, 1'b0);
        chk("rst_busy", bus.dbg_busy, 1'b0);
        chk("rst_ack", bus.dbg_ack, 1'b0);
        chk("rst_rdata", bus.dbg_rdata, 32'h0);
        chk("rst_wen", bus.ram_wen, 1'b0);
        chk("rst_ren", bus.ram_ren, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // debug write then read of reg 5
        dbg_pulse(1'b1, 6'd5, 32'hDEADBEEF);
        wait_ack(40);
        chk("w5_first_wen", first_wen, 1);
        chk("w5_last_wen", last_wen, 16);
        chk("w5_n_wen", n_wen, 16);
        chk("w5_first_waddr", first_waddr, 80);
        chk("w5_first_wdata", first_wdata, 2'b11);
        chk("w5_ack", ack_rel, 17);
        @(negedge clk);
        chk("w5_busy_c18", bus.dbg_busy, 1'b0);
        tick();
        dbg_pulse(1'b0, 6'd5, 32'h0);
        wait_ack(40);
        chk("r5_first_ren", first_ren, 1);
        chk("r5_last_ren", last_ren, 16);
        chk("r5_first_raddr", first_raddr, 80);
        chk("r5_ack", ack_rel, 18);
        chk("r5_rdata", bus.dbg_rdata, 32'hDEADBEEF);
        tick();

        // clear reg 9, then core tenure (writing reg 9 words 0-1) racing a debug write
        dbg_pulse(1'b1, 6'd9, 32'h0);
        wait_ack(40);
        tick();
        bus.core_req = 1'b1;
        dbg_pulse(1'b1, 6'd7, 32'hCAFEF00D);
        @(negedge clk);
        chk("core_gnt_c1", bus.core_gnt, 1'b1);
        chk("core_busy_c1", bus.dbg_busy, 1'b1);
        tick();
        bus.core_wen = 1'b1; bus.core_waddr = 10'(9 * 16); bus.core_wdata = 2'b01;
        tick();
        bus.core_waddr = 10'(9 * 16 + 1); bus.core_wdata = 2'b10;
        tick();
        bus.core_wen = 1'b0;
        while (cyc - t0 < 10) tick();
        bus.core_req = 1'b0;
        wait_ack(60);
        chk("cq_first_wen", first_wen, 11);
        chk("cq_ack", ack_rel, 27);
        tick();
        dbg_pulse(1'b0, 6'd9, 32'h0);
        wait_ack(40);
        chk("r9_rdata", bus.dbg_rdata, 32'h00000009);
        tick();
        dbg_pulse(1'b0, 6'd7, 32'h0);
        wait_ack(40);
        chk("r7_rdata", bus.dbg_rdata, 32'hCAFEF00D);
        tick();

        // invalid targets
        dbg_pulse(1'b1, 6'd0, 32'hFFFFFFFF);
        wait_ack(40);
        chk("w0_n_wen", n_wen, 0);
        chk("w0_ack", ack_rel, 17);
        tick();
        dbg_pulse(1'b1, 6'd40, 32'hFFFFFFFF);
        wait_ack(40);
        chk("w40_n_wen", n_wen, 0);
        chk("w40_ack", ack_rel, 17);
        tick();
        dbg_pulse(1'b0, 6'd0, 32'h0);
        wait_ack(40);
        chk("r0_n_ren", n_ren, 0);
        chk("r0_ack", ack_rel, 18);
        chk("r0_rdata", bus.dbg_rdata, 32'h0);
        tick();

        // a pulse while busy is dropped
        dbg_pulse(1'b1, 6'd6, 32'h12345678);
        tick();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_reg = 6'd6; bus.dbg_wdata = 32'hAAAAAAAA;
        tick();
        bus.dbg_req = 1'b0;
        wait_ack(40);
        chk("drop_ack", ack_rel, 17);
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.dbg_ack) extra++;
        end
        chk("drop_extra_acks", extra, 0);
        tick();
        dbg_pulse(1'b0, 6'd6, 32'h0);
        wait_ack(40);
        chk("r6_rdata", bus.dbg_rdata, 32'h12345678);
        tick();

        // reset in the middle of a read
        dbg_pulse(1'b0, 6'd5, 32'h0);
        while (cyc - t0 < 8) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_ren", bus.ram_ren, 1'b0);
        chk("mid_rst_busy", bus.dbg_busy, 1'b0);
        chk("mid_rst_ack", bus.dbg_ack, 1'b0);
        chk("mid_rst_rdata", bus.dbg_rdata, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        dbg_pulse(1'b0, 6'd5, 32'h0);
        wait_ack(40);
        chk("post_rst_ack", ack_rel, 18);
        chk("post_rst_rdata", bus.dbg_rdata, 32'hDEADBEEF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
